// File: rtl/darkroom_pkg.sv
// Shared encodings for the DarkRoom TS4231 configuration path: sensor state codes,
// scheduler FSM states and the failure-counter ceiling.
package darkroom_pkg;

  localparam logic [2:0] TS_UNKNOWN  = 3'b000;
  localparam logic [2:0] TS_WATCH    = 3'b001;
  localparam logic [2:0] TS_SLEEP    = 3'b010;
  localparam logic [2:0] TS_S3       = 3'b011;
  localparam logic [2:0] TS_BUS_FAIL = 3'b100;

  localparam logic [3:0] FAIL_CNT_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_CFG_RST = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_WAIT    = 3'd4,
    ST_STORE   = 3'd5
  } sched_state_e;

  function automatic logic [3:0] fail_sat_inc(input logic [3:0] cnt);
    return (cnt == FAIL_CNT_MAX) ? FAIL_CNT_MAX : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/ts4231_cfg_timer.sv
// Down-counter shared by the settle and watch-wait phases; tc_o is high once the
// loaded count has run out (count == 0).
module ts4231_cfg_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ts4231_config_scheduler.sv
// Time-multiplexes the single TS4231 configurator over all sensors: round-robin with
// host force preemption, recording per-sensor state, watch flag and failure count.
module ts4231_config_scheduler
  import darkroom_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 8,
  parameter int TIMEOUT_CYCLES    = 5_000_000,
  parameter int SETTLE_CYCLES     = 4,
  parameter int SKIP_WATCHING     = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable_i,
  input  logic [2:0]                     cfg_state_i,
  output logic                           cfg_rst_o,
  output logic [7:0]                     sel_o,
  output logic                           sel_valid_o,
  input  logic                           force_req_i,
  input  logic [7:0]                     force_id_i,
  output logic                           force_ack_o,
  output logic [NUMBER_OF_SENSORS-1:0]   sensor_watch_o,
  output logic [3*NUMBER_OF_SENSORS-1:0] states_o,
  output logic [4*NUMBER_OF_SENSORS-1:0] fail_cnt_o
);

  localparam int N    = NUMBER_OF_SENSORS;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int TW_T = $clog2(TIMEOUT_CYCLES);
  localparam int TW_S = $clog2(SETTLE_CYCLES);
  localparam int TW_M = (TW_T > TW_S) ? TW_T : TW_S;
  localparam int TW   = (TW_M > 0) ? TW_M : 1;

  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LAST_ID     = 8'(N - 1);

  sched_state_e  state_q, state_d;
  logic [7:0]    rr_q, rr_d;
  logic [7:0]    sel_q, sel_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_id_q, pend_id_d;
  logic          ack_q, ack_d;
  logic          success_q, success_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_tc;
  logic          store_en;
  logic [N-1:0]  watch_vec;

  ts4231_cfg_timer #(.WIDTH(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (state_q == ST_IDLE),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      sel_q     <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      ack_q     <= 1'b0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      ack_q     <= ack_d;
      success_q <= success_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    pend_d       = pend_q;
    pend_id_d    = pend_id_q;
    ack_d        = 1'b0;
    success_d    = success_q;
    tmr_load     = 1'b0;
    tmr_load_val = SETTLE_LOAD;
    store_en     = 1'b0;

    // Out-of-range ids are acknowledged so the host never stalls, then dropped.
    if (force_req_i && !pend_q) begin
      ack_d = 1'b1;
      if (int'(force_id_i) < N) begin
        pend_d    = 1'b1;
        pend_id_d = force_id_i;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (pend_q) begin
          pend_d  = 1'b0;
          sel_d   = pend_id_q;
          state_d = ST_CFG_RST;
        end else begin
          rr_d = (rr_q == LAST_ID) ? 8'd0 : rr_q + 8'd1;
          if (!((SKIP_WATCHING != 0) && watch_vec[rr_q[IW-1:0]])) begin
            sel_d   = rr_q;
            state_d = ST_CFG_RST;
          end
        end
      end
      ST_CFG_RST: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          tmr_load     = 1'b1;
          tmr_load_val = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          tmr_load     = 1'b1;
          tmr_load_val = WAIT_LOAD;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (cfg_state_i == TS_WATCH) begin
          success_d = 1'b1;
          state_d   = ST_STORE;
        end else if (tmr_tc) begin
          success_d = 1'b0;
          state_d   = ST_STORE;
        end
      end
      ST_STORE: begin
        store_en = 1'b1;
        state_d  = enable_i ? ST_SELECT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-sensor records; only the sensor under configuration is written, in STORE.
  for (genvar gi = 0; gi < N; gi++) begin : g_sensor
    logic [2:0] state_rec_q;
    logic [3:0] fail_q;
    logic       watch_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        state_rec_q <= TS_UNKNOWN;
        fail_q      <= '0;
        watch_q     <= 1'b0;
      end else if (store_en && (sel_q == 8'(gi))) begin
        if (success_q) begin
          state_rec_q <= TS_WATCH;
          fail_q      <= '0;
          watch_q     <= 1'b1;
        end else begin
          state_rec_q <= cfg_state_i;
          fail_q      <= fail_sat_inc(fail_q);
          watch_q     <= 1'b0;
        end
      end
    end

    assign watch_vec[gi]           = watch_q;
    assign states_o[3*gi +: 3]     = state_rec_q;
    assign fail_cnt_o[4*gi +: 4]   = fail_q;
  end

  assign sensor_watch_o = watch_vec;
  assign cfg_rst_o      = !((state_q == ST_SETTLE) || (state_q == ST_WAIT));
  assign sel_valid_o    = (state_q == ST_CFG_RST) || (state_q == ST_SETTLE) || (state_q == ST_WAIT);
  assign sel_o          = sel_q;
  assign force_ack_o    = ack_q;

endmodule

// File: tb/tb_ts4231_config_scheduler.sv
// Directed bench for the TS4231 configuration scheduler: 4 sensors, 100-cycle timeout,
// 4-cycle settle, with a behavioural configurator answering WATCH 20 cycles after release.
module tb_ts4231_config_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_i = 1'b0;
  logic [2:0]  cfg_state_i = 3'b000;
  logic        cfg_rst_o;
  logic [7:0]  sel_o;
  logic        sel_valid_o;
  logic        force_req_i = 1'b0;
  logic [7:0]  force_id_i = 8'd0;
  logic        force_ack_o;
  logic [3:0]  sensor_watch_o;
  logic [11:0] states_o;
  logic [15:0] fail_cnt_o;

  int tests_run = 0;
  int failed    = 0;

  logic [3:0] stuck = 4'b0000;
  int         mdl_cnt = 0;
  int         low_len = 0;
  int         last_low = 0;
  int         falls = 0;
  logic       prev_rst = 1'b1;
  logic [7:0] sel_log[$];

  ts4231_config_scheduler #(
    .NUMBER_OF_SENSORS (4),
    .TIMEOUT_CYCLES    (100),
    .SETTLE_CYCLES     (4),
    .SKIP_WATCHING     (1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable_i       (enable_i),
    .cfg_state_i    (cfg_state_i),
    .cfg_rst_o      (cfg_rst_o),
    .sel_o          (sel_o),
    .sel_valid_o    (sel_valid_o),
    .force_req_i    (force_req_i),
    .force_id_i     (force_id_i),
    .force_ack_o    (force_ack_o),
    .sensor_watch_o (sensor_watch_o),
    .states_o       (states_o),
    .fail_cnt_o     (fail_cnt_o)
  );

  always #5 clock = ~clock;

  // Configurator model: stuck sensors report S3, others reach WATCH after 20 low cycles.
  always @(negedge clock) begin
    if (cfg_rst_o) mdl_cnt = 0;
    else           mdl_cnt = mdl_cnt + 1;
    if (stuck[sel_o[1:0]])   cfg_state_i = 3'b011;
    else if (mdl_cnt >= 20)  cfg_state_i = 3'b001;
    else                     cfg_state_i = 3'b000;
  end

  always @(negedge clock) begin
    if (reset) begin
      low_len  = 0;
      last_low = 0;
      falls    = 0;
      prev_rst = 1'b1;
      sel_log.delete();
    end else begin
      if (prev_rst && !cfg_rst_o) begin
        falls = falls + 1;
        sel_log.push_back(sel_o);
      end
      if (!cfg_rst_o) begin
        low_len = low_len + 1;
      end else begin
        if (!prev_rst) last_low = low_len;
        low_len = 0;
      end
      prev_rst = cfg_rst_o;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    return (sel_log.size() > i) ? sel_log[i] : 8'hFF;
  endfunction

  initial begin
    int f0;
    int vcnt;
    int lcnt;

    // Reset values
    reset = 1'b1;
    repeat (3) step();
    chk("rst_cfg_rst", cfg_rst_o, 1);
    chk("rst_sel", sel_o, 0);
    chk("rst_sel_valid", sel_valid_o, 0);
    chk("rst_ack", force_ack_o, 0);
    chk("rst_watch", sensor_watch_o, 0);
    chk("rst_states", states_o, 0);
    chk("rst_fail", fail_cnt_o, 0);

    // First round: all sensors reach WATCH in order 0..3
    reset = 1'b0;
    enable_i = 1'b1;
    for (int i = 0; i < 1000 && sensor_watch_o != 4'b1111; i++) step();
    chk("round1_watch", sensor_watch_o, 4'b1111);
    chk("round1_states", states_o, 12'h249);
    chk("round1_fail", fail_cnt_o, 0);
    chk("round1_falls", falls, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("round1_sel%0d", i), log_at(i), i);
    chk("round1_low_len", last_low, 20);

    // Everyone watching: scheduler only skips, never drives the configurator
    f0 = falls;
    vcnt = 0;
    lcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sel_valid_o) vcnt++;
      if (!cfg_rst_o) lcnt++;
    end
    chk("skip_falls", falls, f0);
    chk("skip_sel_valid_cycles", vcnt, 0);
    chk("skip_cfg_low_cycles", lcnt, 0);

    // Sensor 2 stuck in S3: timeout after 4 settle + 100 wait cycles
    reset = 1'b1;
    stuck = 4'b0100;
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 1000 && fail_cnt_o[11:8] != 4'd1; i++) step();
    chk("stuck_fail1", fail_cnt_o[11:8], 1);
    chk("stuck_state", states_o[8:6], 3'b011);
    chk("stuck_low_len", last_low, 104);
    chk("stuck_watch_partial", sensor_watch_o, 4'b0011);
    for (int i = 0; i < 200 && sensor_watch_o != 4'b1011; i++) step();
    chk("stuck_watch_round1", sensor_watch_o, 4'b1011);

    // Disable mid-WAIT on sensor 2: attempt dropped, records untouched
    for (int i = 0; i < 500 && !(!cfg_rst_o && sel_o == 8'd2 && low_len == 50); i++) step();
    chk("dis_reached_wait", (!cfg_rst_o && sel_o == 8'd2 && low_len == 50), 1);
    enable_i = 1'b0;
    step();
    chk("dis_cfg_rst", cfg_rst_o, 1);
    chk("dis_sel_valid", sel_valid_o, 0);
    repeat (5) step();
    chk("dis_fail_kept", fail_cnt_o[11:8], 1);
    chk("dis_state_kept", states_o[8:6], 3'b011);
    chk("dis_idle_cfg_rst", cfg_rst_o, 1);

    // Re-enable and let sensor 2 fail 19 more times: counter saturates at 15
    enable_i = 1'b1;
    f0 = falls;
    for (int i = 0; i < 4000 && falls < f0 + 19; i++) step();
    chk("sat_attempts", falls >= f0 + 19, 1);
    for (int i = 0; i < 200 && !cfg_rst_o; i++) step();
    repeat (2) step();
    chk("sat_fail2", fail_cnt_o[11:8], 15);
    chk("sat_state2", states_o[8:6], 3'b011);
    chk("sat_watch", sensor_watch_o, 4'b1011);
    chk("sat_other_fail", fail_cnt_o & 16'hF0FF, 0);
    chk("sat_other_states", {states_o[11:9], states_o[5:0]}, 9'b001001001);

    // Force sensor 1 while sensor 3 is in WAIT
    reset = 1'b1;
    stuck = 4'b0000;
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 1000 && !(!cfg_rst_o && sel_o == 8'd3 && low_len == 5); i++) step();
    chk("force_s3_wait", (!cfg_rst_o && sel_o == 8'd3), 1);
    force_req_i = 1'b1;
    force_id_i = 8'd1;
    step();
    chk("force_ack_pulse", force_ack_o, 1);
    force_req_i = 1'b0;
    step();
    chk("force_ack_drop", force_ack_o, 0);
    for (int i = 0; i < 300 && falls < 5; i++) step();
    chk("force_falls", falls, 5);
    chk("force_sel_seq3", log_at(3), 3);
    chk("force_sel_forced", log_at(4), 1);
    chk("force_watch_held", sensor_watch_o, 4'b1111);
    chk("force_sel_valid", sel_valid_o, 1);
    for (int i = 0; i < 100 && !cfg_rst_o; i++) step();
    repeat (30) step();
    chk("force_after_falls", falls, 5);
    chk("force_after_states", states_o, 12'h249);

    // Out-of-range force: acknowledged, nothing selected
    force_req_i = 1'b1;
    force_id_i = 8'd7;
    step();
    chk("force7_ack", force_ack_o, 1);
    force_req_i = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sel_valid_o) vcnt++;
    end
    chk("force7_falls", falls, 5);
    chk("force7_sel_valid_cycles", vcnt, 0);

    // Reset mid-WAIT restores every output
    force_req_i = 1'b1;
    force_id_i = 8'd2;
    step();
    force_req_i = 1'b0;
    for (int i = 0; i < 100 && !(!cfg_rst_o && low_len == 5); i++) step();
    chk("mid_rst_sel", sel_o, 2);
    reset = 1'b1;
    step();
    chk("mid_rst_cfg_rst", cfg_rst_o, 1);
    chk("mid_rst_sel_o", sel_o, 0);
    chk("mid_rst_sel_valid", sel_valid_o, 0);
    chk("mid_rst_ack", force_ack_o, 0);
    chk("mid_rst_watch", sensor_watch_o, 0);
    chk("mid_rst_states", states_o, 0);
    chk("mid_rst_fail", fail_cnt_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
